// File: rtl/sequence_buffer_pkg.sv
// rtl/sequence_buffer_pkg.sv - shared types for the sequence buffer
// Purpose: playback FSM state encoding used by sequence_buffer.
// Ports: none (package).
package sequence_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/sequence_store.sv
// rtl/sequence_store.sv - reset-able symbol array with write, playback and registered read ports
// Purpose: storage for sequence_buffer.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (zeroes every entry)
//   wr_en/wr_addr/wr_data single write port
//   play_addr/play_data   combinational index read used by playback
//   rd_addr/rd_data       registered random read (read-before-write on collision)
import sequence_buffer_pkg::*;

module sequence_store #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] play_addr,
  output logic [DATA_W-1:0] play_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  // Indices past DEPTH exist only when DEPTH is not a power of two; they read as 0.
  assign play_data = ({1'b0, play_addr} < DEPTH_X) ? mem[play_addr] : '0;
  assign rd_word   = ({1'b0, rd_addr}   < DEPTH_X) ? mem[rd_addr]   : '0;

  // rd_data samples the pre-write contents, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= rd_word;
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sequence_buffer.sv
// rtl/sequence_buffer.sv - append-only symbol sequence with streamed playback and random read
// Purpose: records up to DEPTH symbols, replays them in order over a valid/ready stream.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   clear                           synchronous empty + playback abort (wins over wr_en/play_start)
//   wr_en, wr_data, wr_drop         append port; wr_drop pulses the cycle after a rejected write
//   play_start                      start playback from entry 0
//   out_valid/out_ready/out_data/out_last  playback stream
//   rd_addr, rd_data                registered random read
//   length, empty, full, busy       status
import sequence_buffer_pkg::*;

module sequence_buffer #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              play_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  length,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  ptr;
  logic [DATA_W-1:0] play_data;
  logic [ADDR_W-1:0] play_addr;
  logic              wr_accept, wr_reject, start, xfer, xfer_more, xfer_end;

  assign full  = (length == DEPTH_C);
  assign empty = (length == '0);
  assign busy  = (state == PLAY);

  assign wr_accept = wr_en & ~clear & (state == IDLE) & ~full;
  assign wr_reject = wr_en & ~clear & ~wr_accept;
  assign start     = (state == IDLE) & play_start & ~empty & ~clear;
  assign xfer      = out_valid & out_ready;
  assign xfer_more = xfer & (ptr < length);
  assign xfer_end  = xfer & (ptr == length);

  // ptr already points at the symbol after the one on out_data.
  assign out_last  = out_valid & (ptr == length);
  assign play_addr = start ? '0 : ptr[ADDR_W-1:0];

  sequence_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_accept),
    .wr_addr   (length[ADDR_W-1:0]),
    .wr_data   (wr_data),
    .play_addr (play_addr),
    .play_data (play_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)                          state_nxt = IDLE;
    else if (start)                     state_nxt = PLAY;
    else if (state == PLAY && xfer_end) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length    <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= wr_reject;
      if (clear) begin
        length    <= '0;
        ptr       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (wr_accept) length <= length + CNT_W'(1);
        if (start) begin
          out_data  <= play_data;
          out_valid <= 1'b1;
          ptr       <= CNT_W'(1);
        end else if (xfer_more) begin
          out_data <= play_data;
          ptr      <= ptr + CNT_W'(1);
        end else if (xfer_end) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_buffer.sv
// tb/tb_sequence_buffer.sv - self-checking bench for sequence_buffer
module tb_sequence_buffer;

  localparam int DW = 2;
  localparam int D  = 4;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst, clear, wr_en, play_start, out_ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          wr_drop, out_valid, out_last, empty, full, busy;
  logic [DW-1:0] out_data, rd_data;
  logic [CW-1:0] length;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: stored symbols and count; storage survives clear, not reset.
  int model_mem [D];
  int model_len;

  always #5 clk = ~clk;

  sequence_buffer #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_drop    (wr_drop),
    .play_start (play_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .length     (length),
    .empty      (empty),
    .full       (full),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_length"}, 32'(length), 32'(model_len));
    check({tag, "_empty"},  32'(empty),  32'(model_len == 0));
    check({tag, "_full"},   32'(full),   32'(model_len == D));
  endtask

  // Append in IDLE; rejected only when the model is full.
  task automatic do_write(input int d);
    bit drop;
    drop    = (model_len == D);
    wr_en   = 1'b1;
    wr_data = DW'(d);
    step();
    wr_en = 1'b0;
    check("wr_drop", 32'(wr_drop), 32'(drop));
    if (!drop) begin
      model_mem[model_len] = d;
      model_len++;
    end
    check_status("wr");
    step();
    check("wr_drop_clear", 32'(wr_drop), 32'd0);
  endtask

  task automatic start_play();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
  endtask

  // Consume the whole sequence with random backpressure; expected stream is model_mem[0..len-1].
  task automatic drain(input bit random_ready);
    int k = 0;
    int budget = 200;
    bit rdy;
    while (k < model_len && budget > 0) begin
      check("pl_valid", 32'(out_valid), 32'd1);
      check("pl_data",  32'(out_data),  32'(model_mem[k]));
      check("pl_last",  32'(out_last),  32'(k == model_len - 1));
      check("pl_busy",  32'(busy),      32'd1);
      rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      step();
      if (rdy) k++;
      budget--;
    end
    if (budget == 0) check("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    check("pl_end_valid", 32'(out_valid), 32'd0);
    check("pl_end_busy",  32'(busy),      32'd0);
    check("pl_end_last",  32'(out_last),  32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_len = 0;
    check_status("clr");
    check("clr_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; play_start = 1'b0; out_ready = 1'b0;
    wr_data = '0; rd_addr = '0;
    model_len = 0;
    for (int i = 0; i < D; i++) model_mem[i] = 0;
    step();
    step();
    rst = 1'b0;
    check_status("por");
    check("por_valid", 32'(out_valid), 32'd0);
    check("por_busy",  32'(busy),      32'd0);

    // Async reset mid-playback.
    do_write(2);
    do_write(1);
    start_play();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    model_len = 0;
    for (int i = 0; i < D; i++) model_mem[i] = 0;
    check_status("arst");
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  32'(out_data),  32'd0);
    check("arst_last",  32'(out_last),  32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_drop",  32'(wr_drop),   32'd0);
    check("arst_rd",    32'(rd_data),   32'd0);
    step();
    rst = 1'b0;

    // Fill 3,1,2,0 then overflow write.
    do_write(3);
    do_write(1);
    do_write(2);
    do_write(0);
    do_write(3);

    // Random read of every index.
    for (int a = 0; a < D; a++) begin
      rd_addr = AW'(a);
      step();
      check("rd_data", 32'(rd_data), 32'(model_mem[a]));
    end

    // Full-rate playback.
    start_play();
    drain(1'b0);

    // Backpressure while out_data=1.
    start_play();
    check("bp_first", 32'(out_data), 32'(model_mem[0]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_hold_data",  32'(out_data),  32'(model_mem[1]));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_resume", 32'(out_data), 32'(model_mem[2]));
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    check("bp_done", 32'(busy), 32'd0);

    // Abort with clear on the second beat, together with wr_en.
    start_play();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ab_beat2", 32'(out_data), 32'(model_mem[1]));
    clear = 1'b1; wr_en = 1'b1; wr_data = 2'd3;
    step();
    clear = 1'b0; wr_en = 1'b0;
    model_len = 0;
    check_status("ab");
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_busy",  32'(busy),      32'd0);
    check("ab_drop",  32'(wr_drop),   32'd0);

    // play_start while empty.
    start_play();
    check("empty_start_valid", 32'(out_valid), 32'd0);
    check("empty_start_busy",  32'(busy),      32'd0);

    // Read-before-write: index 0 still holds the stale 3.
    rd_addr = '0;
    wr_en = 1'b1; wr_data = 2'd1;
    step();
    wr_en = 1'b0;
    check("rbw_old", 32'(rd_data), 32'(model_mem[0]));
    model_mem[0] = 1;
    model_len = 1;
    step();
    check("rbw_new", 32'(rd_data), 32'd1);
    do_write(2);

    // Write during playback is dropped.
    start_play();
    wr_en = 1'b1; wr_data = 2'd0;
    step();
    wr_en = 1'b0;
    check("play_wr_drop", 32'(wr_drop), 32'd1);
    check_status("play_wr");
    drain(1'b1);

    // Randomised rounds.
    for (int r = 0; r < 12; r++) begin
      do_clear();
      n = $urandom_range(1, D + 1);
      for (int i = 0; i < n; i++) do_write(int'($urandom_range(0, (1 << DW) - 1)));
      for (int i = 0; i < 3; i++) begin
        int a;
        a = int'($urandom_range(0, D - 1));
        rd_addr = AW'(a);
        step();
        check("rnd_rd", 32'(rd_data), 32'(model_mem[a]));
      end
      start_play();
      drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
